// File: rtl/audio_mixer.sv
`default_nettype none
// ============================================================================
// Module   : audio_mixer
// Brief    : Time-multiplexed stereo voice mixer with master volume,
//            16-bit saturation and sticky clip/overrun flags.
// Revision : 1.0 - initial release
// ============================================================================
module audio_mixer #(
    parameter int NUM_VOICES  = 4,
    parameter int UNITY_SHIFT = 7
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    sample_tick,
    input  logic [16*NUM_VOICES-1:0] voice_left,
    input  logic [16*NUM_VOICES-1:0] voice_right,
    input  logic [NUM_VOICES-1:0]   voice_mute,
    input  logic [7:0]              master_vol,
    input  logic                    clr_flags,
    output logic [15:0]             mix_left,
    output logic [15:0]             mix_right,
    output logic                    mix_valid,
    output logic                    busy,
    output logic                    clip_left,
    output logic                    clip_right,
    output logic                    overrun
);

    localparam int c_idx_w  = $clog2(NUM_VOICES);
    localparam int c_acc_w  = 16 + c_idx_w + 1;
    localparam int c_prod_w = c_acc_w + 9;

    localparam logic [c_idx_w-1:0]         c_last_idx = c_idx_w'(NUM_VOICES - 1);
    localparam logic signed [c_prod_w-1:0] c_sat_max  = c_prod_w'(32767);
    localparam logic signed [c_prod_w-1:0] c_sat_min  = c_prod_w'(-32768);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_SCALE  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic signed [15:0]         r_snap_left  [NUM_VOICES];
    logic signed [15:0]         r_snap_right [NUM_VOICES];
    logic [NUM_VOICES-1:0]      r_snap_mute;
    logic [7:0]                 r_snap_vol;
    logic [c_idx_w-1:0]         r_index;
    logic signed [c_acc_w-1:0]  r_acc_left;
    logic signed [c_acc_w-1:0]  r_acc_right;
    logic signed [c_prod_w-1:0] r_scaled_left;
    logic signed [c_prod_w-1:0] r_scaled_right;

    logic signed [c_acc_w-1:0]  w_add_left;
    logic signed [c_acc_w-1:0]  w_add_right;
    logic signed [8:0]          w_vol_s;
    logic signed [c_prod_w-1:0] w_prod_left;
    logic signed [c_prod_w-1:0] w_prod_right;
    logic                       w_ovf_left;
    logic                       w_ovf_right;
    logic                       w_in_output;

    function automatic logic [15:0] sat16(input logic signed [c_prod_w-1:0] v);
        if (v > c_sat_max) begin
            return 16'h7FFF;
        end else if (v < c_sat_min) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

    always_comb begin
        w_add_left  = '0;
        w_add_right = '0;
        if (!r_snap_mute[r_index]) begin
            w_add_left  = c_acc_w'(r_snap_left[r_index]);
            w_add_right = c_acc_w'(r_snap_right[r_index]);
        end
    end

    // Zero-extended gain keeps master_vol unsigned inside a signed multiply.
    assign w_vol_s      = {1'b0, r_snap_vol};
    assign w_prod_left  = c_prod_w'(r_acc_left) * c_prod_w'(w_vol_s);
    assign w_prod_right = c_prod_w'(r_acc_right) * c_prod_w'(w_vol_s);
    assign w_ovf_left   = (r_scaled_left > c_sat_max) || (r_scaled_left < c_sat_min);
    assign w_ovf_right  = (r_scaled_right > c_sat_max) || (r_scaled_right < c_sat_min);
    assign w_in_output  = (r_state == ST_OUTPUT);
    assign busy         = (r_state != ST_IDLE);

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (sample_tick) w_state_next = ST_ACCUM;
            ST_ACCUM:  if (r_index == c_last_idx) w_state_next = ST_SCALE;
            ST_SCALE:  w_state_next = ST_OUTPUT;
            ST_OUTPUT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_snap_left[i]  <= '0;
                r_snap_right[i] <= '0;
            end
            r_snap_mute    <= '0;
            r_snap_vol     <= '0;
            r_index        <= '0;
            r_acc_left     <= '0;
            r_acc_right    <= '0;
            r_scaled_left  <= '0;
            r_scaled_right <= '0;
            mix_left       <= '0;
            mix_right      <= '0;
            mix_valid      <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            r_snap_left[i]  <= voice_left[16*i +: 16];
                            r_snap_right[i] <= voice_right[16*i +: 16];
                        end
                        r_snap_mute <= voice_mute;
                        r_snap_vol  <= master_vol;
                        r_index     <= '0;
                        r_acc_left  <= '0;
                        r_acc_right <= '0;
                    end
                end
                ST_ACCUM: begin
                    r_acc_left  <= r_acc_left + w_add_left;
                    r_acc_right <= r_acc_right + w_add_right;
                    r_index     <= (r_index == c_last_idx) ? '0 : r_index + c_idx_w'(1);
                end
                ST_SCALE: begin
                    r_scaled_left  <= w_prod_left >>> UNITY_SHIFT;
                    r_scaled_right <= w_prod_right >>> UNITY_SHIFT;
                end
                ST_OUTPUT: begin
                    mix_left  <= sat16(r_scaled_left);
                    mix_right <= sat16(r_scaled_right);
                    mix_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clr_flags takes priority.
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            clip_left  <= 1'b0;
            clip_right <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (w_in_output && w_ovf_left) begin
                clip_left <= 1'b1;
            end else if (clr_flags) begin
                clip_left <= 1'b0;
            end
            if (w_in_output && w_ovf_right) begin
                clip_right <= 1'b1;
            end else if (clr_flags) begin
                clip_right <= 1'b0;
            end
            if (sample_tick && busy) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_mixer
// Brief    : Directed self-checking bench for audio_mixer (4 voices).
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_mixer;

    logic        clk_50mhz;
    logic        reset;
    logic        sample_tick;
    logic [63:0] voice_left;
    logic [63:0] voice_right;
    logic [3:0]  voice_mute;
    logic [7:0]  master_vol;
    logic        clr_flags;
    logic [15:0] mix_left;
    logic [15:0] mix_right;
    logic        mix_valid;
    logic        busy;
    logic        clip_left;
    logic        clip_right;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    audio_mixer #(.NUM_VOICES(4), .UNITY_SHIFT(7)) dut (
        .clk_50mhz   (clk_50mhz),
        .reset       (reset),
        .sample_tick (sample_tick),
        .voice_left  (voice_left),
        .voice_right (voice_right),
        .voice_mute  (voice_mute),
        .master_vol  (master_vol),
        .clr_flags   (clr_flags),
        .mix_left    (mix_left),
        .mix_right   (mix_right),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .clip_left   (clip_left),
        .clip_right  (clip_right),
        .overrun     (overrun)
    );

    initial clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50mhz);
        #1;
    endtask

    // Tick, scramble inputs after capture, wait for mix_valid, check result.
    // clr_at >= 0 raises clr_flags during that post-capture cycle.
    task automatic do_mix(input string tag, input logic [15:0] exp_l,
                          input logic [15:0] exp_r, input int clr_at);
        int          cyc;
        logic [63:0] sv_l;
        logic [63:0] sv_r;
        logic [3:0]  sv_m;
        logic [7:0]  sv_v;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        sv_l = voice_left;
        sv_r = voice_right;
        sv_m = voice_mute;
        sv_v = master_vol;
        voice_left  = ~voice_left;
        voice_right = ~voice_right;
        voice_mute  = ~voice_mute;
        master_vol  = 8'd0;
        cyc = 0;
        while (mix_valid !== 1'b1 && cyc < 20) begin
            chk({tag, "/busy"}, 16'(busy), 16'd1);
            clr_flags = (cyc == clr_at);
            step();
            cyc++;
        end
        clr_flags = 1'b0;
        chk({tag, "/latency"}, 16'(cyc), 16'd6);
        chk({tag, "/left"}, mix_left, exp_l);
        chk({tag, "/right"}, mix_right, exp_r);
        chk({tag, "/busy_done"}, 16'(busy), 16'd0);
        voice_left  = sv_l;
        voice_right = sv_r;
        voice_mute  = sv_m;
        master_vol  = sv_v;
        step();
        chk({tag, "/valid_pulse"}, 16'(mix_valid), 16'd0);
        chk({tag, "/hold"}, mix_left, exp_l);
    endtask

    task automatic chk_flags(input string tag, input logic cl, input logic cr, input logic ov);
        chk({tag, "/clip_left"}, 16'(clip_left), 16'(cl));
        chk({tag, "/clip_right"}, 16'(clip_right), 16'(cr));
        chk({tag, "/overrun"}, 16'(overrun), 16'(ov));
    endtask

    task automatic count_valid(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (mix_valid === 1'b1) pulses++;
        end
    endtask

    initial begin
        int cyc;
        int pulses;
        reset       = 1'b1;
        sample_tick = 1'b0;
        voice_left  = '0;
        voice_right = '0;
        voice_mute  = '0;
        master_vol  = 8'd128;
        clr_flags   = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        chk("reset/left", mix_left, 16'd0);
        chk("reset/right", mix_right, 16'd0);
        chk("reset/valid", 16'(mix_valid), 16'd0);
        chk("reset/busy", 16'(busy), 16'd0);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);

        // Basic mix at unity gain
        voice_left  = {16'sd0, -16'sd500, 16'sd2000, 16'sd1000};
        voice_right = {16'sd100, 16'sd0, 16'sd0, 16'sd0};
        voice_mute  = 4'b0000;
        master_vol  = 8'd128;
        do_mix("unity", 16'd2500, 16'd100, -1);
        chk_flags("unity", 1'b0, 1'b0, 1'b0);

        // Mute voice 1, half gain
        voice_mute = 4'b0010;
        master_vol = 8'd64;
        do_mix("mute_half", 16'd250, 16'd50, -1);

        // Positive and negative saturation
        voice_left  = {4{16'h7FFF}};
        voice_right = {4{16'h7FFF}};
        voice_mute  = 4'b0000;
        master_vol  = 8'd255;
        do_mix("sat_pos", 16'h7FFF, 16'h7FFF, -1);
        chk_flags("sat_pos", 1'b1, 1'b1, 1'b0);
        voice_left  = {4{16'h8000}};
        voice_right = {4{16'h8000}};
        do_mix("sat_neg", 16'h8000, 16'h8000, -1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk_flags("clear", 1'b0, 1'b0, 1'b0);

        // Floor shift toward minus infinity: -192 >>> 7 = -2
        voice_left  = {16'sd0, 16'sd0, 16'sd0, -16'sd3};
        voice_right = '0;
        master_vol  = 8'd64;
        do_mix("floor", 16'hFFFE, 16'd0, -1);

        // Second tick two cycles into a mix
        voice_left  = {16'sd0, -16'sd500, 16'sd2000, 16'sd1000};
        voice_right = {16'sd100, 16'sd0, 16'sd0, 16'sd0};
        master_vol  = 8'd128;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        cyc = 2;
        while (mix_valid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("overrun/latency", 16'(cyc), 16'd6);
        chk("overrun/left", mix_left, 16'd2500);
        chk("overrun/right", mix_right, 16'd100);
        chk_flags("overrun", 1'b0, 1'b0, 1'b1);
        count_valid(12, pulses);
        chk("overrun/no_second_mix", 16'(pulses), 16'd0);

        // clr_flags in the same cycle as a clip event: set wins
        voice_left  = {4{16'h7FFF}};
        voice_right = {4{16'h7FFF}};
        master_vol  = 8'd255;
        do_mix("clr_vs_set", 16'h7FFF, 16'h7FFF, 5);
        chk_flags("clr_vs_set", 1'b1, 1'b1, 1'b0);

        // Reset three cycles into a mix
        voice_left  = {16'sd0, -16'sd500, 16'sd2000, 16'sd1000};
        voice_right = {16'sd100, 16'sd0, 16'sd0, 16'sd0};
        master_vol  = 8'd128;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        chk("abort/left", mix_left, 16'd0);
        chk("abort/right", mix_right, 16'd0);
        chk("abort/valid", 16'(mix_valid), 16'd0);
        chk("abort/busy", 16'(busy), 16'd0);
        chk_flags("abort", 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        count_valid(10, pulses);
        chk("abort/no_mix", 16'(pulses), 16'd0);
        do_mix("post_abort", 16'd2500, 16'd100, -1);
        chk_flags("post_abort", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_mixer.md
# audio_mixer

Time-multiplexed stereo mixer that sits directly downstream of the per-voice generators (triangle/saw, noise, square). On each 48 kHz sample tick it captures every voice's signed 16-bit left/right output, sums them sequentially, applies a master volume, saturates to 16 bits, and presents one stereo sample with a valid strobe to the DAC/serializer stage. It runs entirely on the 50 MHz system clock.

## Interface
- NUM_VOICES, 4, number of voice inputs (2..16).
- UNITY_SHIFT, 7, right shift applied after master-volume multiply; master_vol = 2^UNITY_SHIFT (128) is unity gain.

- clk_50mhz  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_tick  input  1  one-cycle pulse per output sample, synchronous to clk_50mhz.
- voice_left  input  16*NUM_VOICES  signed per-voice left samples; voice i at bits [16*i+15:16*i].
- voice_right  input  16*NUM_VOICES  signed per-voice right samples, same packing.
- voice_mute  input  NUM_VOICES  bit i = 1 excludes voice i from the sum.
- master_vol  input  8  unsigned master gain.
- clr_flags  input  1  one-cycle pulse; clears clip_left, clip_right, overrun.
- mix_left  output  16  signed mixed left sample.
- mix_right  output  16  signed mixed right sample.
- mix_valid  output  1  one-cycle pulse when mix_left/mix_right update.
- busy  output  1  high while a mix is in progress (any state except IDLE).
- clip_left  output  1  sticky: left saturated since last clear.
- clip_right  output  1  sticky: right saturated since last clear.
- overrun  output  1  sticky: sample_tick arrived while busy.

## Operation
- States: IDLE, ACCUM, SCALE, OUTPUT.
- IDLE: on sample_tick, capture voice_left, voice_right, voice_mute and master_vol into snapshot registers, clear both accumulators, set index = 0, go to ACCUM. Inputs may change freely after the capture edge.
- ACCUM: each cycle, add snapshot voice[index] left/right to the accumulators unless its captured mute bit is set (add 0 instead). Increment index. After index NUM_VOICES-1 is added, go to SCALE.
- SCALE: product = accumulator (signed) × {1'b0, master_vol} (signed 9-bit); result = product >>> UNITY_SHIFT (arithmetic, floor toward −inf). Register the results. Go to OUTPUT.
- OUTPUT: saturate each channel to [−32768, +32767] and load mix_left/mix_right. Pulse mix_valid for one cycle. Set clip_x if channel x saturated. Return to IDLE.
- Widths: accumulator = 16 + ceil(log2(NUM_VOICES)) + 1 bits, so no wrap is possible. Product/shift path is wide enough for no intermediate overflow. Saturation is the only lossy step besides the floor shift.
- sample_tick in any state other than IDLE is ignored for mixing and sets overrun. The in-progress mix completes unchanged.
- Sticky flags: clr_flags clears all three. If a set condition and clr_flags occur in the same cycle, set wins.
- master_vol = 0 yields 0 on both channels, with no clip.

## Timing
- Reset (async assert, sync-safe deassert): state = IDLE; mix_left = mix_right = 0; mix_valid = 0; busy = 0; clip_left = clip_right = overrun = 0; accumulators/index = 0.
- Reset asserted mid-mix aborts the mix. No mix_valid is produced for that tick.
- Tick sampled at edge E0 (capture).
- Accumulation occurs at edges E1..E_N (N = NUM_VOICES).
- Scale occurs at E_{N+1}. Output registers and mix_valid are set at E_{N+2}.
- Latency from tick to mix_valid = NUM_VOICES + 2 cycles (6 for default).
- busy is high from E0 through E_{N+2}. It is low again the cycle after mix_valid, so back-to-back ticks must be at least N+3 cycles apart. At 48 kHz (~1041 cycles) this is always satisfied.
- mix_left/mix_right hold their value between mix_valid pulses.
- A sample_tick coincident with the mix_valid cycle (state OUTPUT) counts as overrun.

## Test plan
- Reset then single tick, voices L = {1000, 2000, −500, 0}, R = {0, 0, 0, 100}, mute = 0, master_vol = 128 -> mix_valid exactly 6 cycles after tick; mix_left = 2500, mix_right = 100; busy high for the 6 intervening cycles; no flags set.
- Same voices with voice_mute = 4'b0010 and master_vol = 64 -> mix_left = (−1000+... i.e. 1000−500) × 64 >>> 7 = 250; mix_right = 50.
- Four voices at +32767 on both channels, master_vol = 255 -> mix_left = mix_right = 32767; clip_left = clip_right = 1. Four voices at −32768 -> −32768. Then clr_flags -> flags 0.
- Negative floor check: single voice L = −3, others 0, master_vol = 64 -> mix_left = −2 (−192 >>> 7).
- sample_tick reasserted 2 cycles after the first -> the first mix completes with correct values; no second mix_valid; overrun = 1. clr_flags asserted in the same cycle as a new clip event -> clip flag stays 1.
- Reset asserted 3 cycles into a mix -> all outputs 0 immediately; no mix_valid. The next tick after release produces a correct mix.
